// File: rtl/if_fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: opcodes, exec state and
// fetch FSM states.
package if_fetch_unit_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 5'h00,
    OP_JUMP = 5'h10,
    OP_JMPR = 5'h11,
    OP_BZ   = 5'h12,
    OP_BNZ  = 5'h13,
    OP_BN   = 5'h14,
    OP_BNN  = 5'h15,
    OP_BC   = 5'h16,
    OP_BNC  = 5'h17,
    OP_HALT = 5'h1F
  } opcode_e;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_EXEC = 1'b1
  } exec_e;

  typedef enum logic {
    FSM_RUN  = 1'b0,
    FSM_HALT = 1'b1
  } fsm_e;

endpackage

// File: rtl/if_branch_resolve.sv
// Combinational resolution of the MEM-stage branch / JMPR into a redirect.
module if_branch_resolve
  import if_fetch_unit_pkg::*;
#(
  parameter int IR_W = 16,
  parameter int OP_W = 5
) (
  input  logic [IR_W-1:0] mem_ir,
  input  logic            zf,
  input  logic            nf,
  input  logic            cf,
  output logic            mem_redirect
);

  localparam logic [OP_W-1:0] C_JMPR = OP_W'(OP_JMPR);
  localparam logic [OP_W-1:0] C_BZ   = OP_W'(OP_BZ);
  localparam logic [OP_W-1:0] C_BNZ  = OP_W'(OP_BNZ);
  localparam logic [OP_W-1:0] C_BN   = OP_W'(OP_BN);
  localparam logic [OP_W-1:0] C_BNN  = OP_W'(OP_BNN);
  localparam logic [OP_W-1:0] C_BC   = OP_W'(OP_BC);
  localparam logic [OP_W-1:0] C_BNC  = OP_W'(OP_BNC);

  logic [OP_W-1:0] op;
  logic            unused_operand;

  assign op             = mem_ir[IR_W-1 -: OP_W];
  assign unused_operand = ^mem_ir[IR_W-OP_W-1:0];

  always_comb begin
    mem_redirect = 1'b0;
    case (op)
      C_BZ:    mem_redirect = zf;
      C_BNZ:   mem_redirect = ~zf;
      C_BN:    mem_redirect = nf;
      C_BNN:   mem_redirect = ~nf;
      C_BC:    mem_redirect = cf;
      C_BNC:   mem_redirect = ~cf;
      C_JMPR:  mem_redirect = 1'b1;
      default: mem_redirect = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, feeds ID through a valid/ready
// register, resolves ID JUMPs and MEM redirects, and parks in HALT.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                PC_W     = 8,
  parameter int                IR_W     = 16,
  parameter int                OP_W     = 5,
  parameter int                DATA_W   = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [IR_W-1:0]   NOP_IR   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic              id_ready,
  input  logic [IR_W-1:0]   mem_ir,
  input  logic [DATA_W-1:0] reg_C,
  input  logic              zf,
  input  logic              nf,
  input  logic              cf,
  input  logic [IR_W-1:0]   i_datain,
  output logic [PC_W-1:0]   i_addr,
  output logic [IR_W-1:0]   id_ir,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid,
  output logic              flush,
  output logic              halted
);

  localparam logic [OP_W-1:0] C_JUMP = OP_W'(OP_JUMP);
  localparam logic [OP_W-1:0] C_HALT = OP_W'(OP_HALT);

  logic [PC_W-1:0] pc;
  fsm_e            fsm;
  logic            mem_redirect;
  logic [OP_W-1:0] id_op;
  logic            id_jump;
  logic            halt_take;
  logic            unused_reg_c;

  if_branch_resolve #(
    .IR_W (IR_W),
    .OP_W (OP_W)
  ) u_resolve (
    .mem_ir       (mem_ir),
    .zf           (zf),
    .nf           (nf),
    .cf           (cf),
    .mem_redirect (mem_redirect)
  );

  assign id_op        = id_ir[IR_W-1 -: OP_W];
  assign id_jump      = id_valid & (id_op == C_JUMP);
  // HALT is only taken once ID actually accepts it.
  assign halt_take    = id_valid & id_ready & (id_op == C_HALT);
  assign i_addr       = pc;
  assign halted       = (fsm == FSM_HALT);
  assign unused_reg_c = ^reg_C[DATA_W-1:PC_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      id_ir    <= NOP_IR;
      id_pc    <= '0;
      id_valid <= 1'b0;
      flush    <= 1'b0;
      fsm      <= FSM_RUN;
    end else if (state == ST_EXEC) begin
      flush <= 1'b0;
      if (mem_redirect) begin
        // Redirect from MEM beats stall, HALT and any JUMP sitting in ID.
        pc       <= reg_C[PC_W-1:0];
        id_ir    <= NOP_IR;
        id_valid <= 1'b0;
        flush    <= 1'b1;
        fsm      <= FSM_RUN;
      end else if ((fsm == FSM_HALT) || halt_take) begin
        id_ir    <= NOP_IR;
        id_valid <= 1'b0;
        fsm      <= FSM_HALT;
      end else if (!id_ready) begin
        pc <= pc;
      end else if (id_jump) begin
        // Squash the wrong-path fetch: no delay slot.
        pc       <= id_ir[PC_W-1:0];
        id_ir    <= NOP_IR;
        id_valid <= 1'b0;
      end else begin
        id_ir    <= i_datain;
        id_pc    <= pc;
        id_valid <= 1'b1;
        pc       <= pc + 1'b1;
      end
    end else begin
      flush <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized check of if_fetch_unit against a cycle-level
// reference model of the fetch rules.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset, state, id_ready, zf, nf, cf;
  logic [15:0] mem_ir, reg_C, i_datain;
  logic [7:0]  i_addr, id_pc;
  logic [15:0] id_ir;
  logic        id_valid, flush, halted;

  logic [15:0] imem [256];

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          m_pc, m_idpc;
  logic [15:0] m_ir;
  bit          m_valid, m_flush, m_halt;

  always #5 clock = ~clock;

  assign i_datain = imem[i_addr];

  if_fetch_unit dut (
    .clock    (clock),
    .reset    (reset),
    .state    (state),
    .id_ready (id_ready),
    .mem_ir   (mem_ir),
    .reg_C    (reg_C),
    .zf       (zf),
    .nf       (nf),
    .cf       (cf),
    .i_datain (i_datain),
    .i_addr   (i_addr),
    .id_ir    (id_ir),
    .id_pc    (id_pc),
    .id_valid (id_valid),
    .flush    (flush),
    .halted   (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit branch_taken(input logic [15:0] ir);
    case (ir[15:11])
      OP_BZ:   return zf;
      OP_BNZ:  return !zf;
      OP_BN:   return nf;
      OP_BNN:  return !nf;
      OP_BC:   return cf;
      OP_BNC:  return !cf;
      OP_JMPR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Next-state of the fetch stage from the current inputs, rule by rule.
  task automatic model_edge();
    bit redir, jump, take_halt;
    if (reset) begin
      m_pc = 0; m_ir = 16'h0; m_idpc = 0; m_valid = 0; m_flush = 0; m_halt = 0;
      return;
    end
    m_flush = 0;
    if (!state) return;
    redir     = branch_taken(mem_ir);
    jump      = m_valid && (m_ir[15:11] == OP_JUMP);
    take_halt = m_valid && id_ready && (m_ir[15:11] == OP_HALT);
    if (redir) begin
      m_pc = int'(reg_C) % 256; m_ir = 16'h0; m_valid = 0; m_flush = 1; m_halt = 0;
    end else if (m_halt || take_halt) begin
      m_ir = 16'h0; m_valid = 0; m_halt = 1;
    end else if (!id_ready) begin
      // stall: everything holds
    end else if (jump) begin
      m_pc = int'(m_ir[7:0]); m_ir = 16'h0; m_valid = 0;
    end else begin
      m_ir = imem[m_pc]; m_idpc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("model_i_addr",   32'(i_addr),   32'(m_pc));
    chk("model_id_ir",    32'(id_ir),    32'(m_ir));
    chk("model_id_pc",    32'(id_pc),    32'(m_idpc));
    chk("model_id_valid", 32'(id_valid), 32'(m_valid));
    chk("model_flush",    32'(flush),    32'(m_flush));
    chk("model_halted",   32'(halted),   32'(m_halt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) imem[i] = {5'h01, 3'b000, 8'(i)};
    w = {OP_JUMP, 11'h040};  imem[7]    = w;
    w = {OP_HALT, 11'h000};  imem[8'h0A] = w;

    reset = 1; state = 1; id_ready = 1; mem_ir = 16'h0; reg_C = 16'h0;
    zf = 0; nf = 0; cf = 0;

    // reset state
    tick();
    chk("rst_i_addr", 32'(i_addr), 32'h0);
    chk("rst_valid",  32'(id_valid), 32'h0);
    chk("rst_flush",  32'(flush), 32'h0);
    reset = 0;

    // sequential fetch
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("seq_i_addr", 32'(i_addr), 32'(k));
      chk("seq_id_pc",  32'(id_pc),  32'(k - 1));
      chk("seq_valid",  32'(id_valid), 32'h1);
      chk("seq_flush",  32'(flush), 32'h0);
    end
    tick();

    // stall at pc=5
    id_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_i_addr", 32'(i_addr), 32'h5);
      chk("stall_id_pc",  32'(id_pc),  32'h4);
    end
    id_ready = 1;
    tick();
    chk("release_i_addr", 32'(i_addr), 32'h6);

    // JUMP 0x40 from address 7
    tick();
    tick();
    chk("jump_in_id", 32'(id_ir), 32'({OP_JUMP, 11'h040}));
    tick();
    chk("jump_i_addr", 32'(i_addr), 32'h40);
    chk("jump_bubble", 32'(id_valid), 32'h0);
    tick();
    chk("jump_id_pc", 32'(id_pc), 32'h40);

    // BZ taken during a stall
    mem_ir = {OP_BZ, 11'h0}; zf = 1; reg_C = 16'h1234; id_ready = 0;
    tick();
    chk("bz_i_addr", 32'(i_addr), 32'h34);
    chk("bz_flush",  32'(flush), 32'h1);
    chk("bz_valid",  32'(id_valid), 32'h0);
    mem_ir = 16'h0; zf = 0; id_ready = 1;
    tick();
    chk("bz_flush_drop", 32'(flush), 32'h0);
    chk("bz_target_pc",  32'(id_pc), 32'h34);

    // BZ not taken
    mem_ir = {OP_BZ, 11'h0}; zf = 0; reg_C = 16'h1234;
    tick();
    chk("bznt_i_addr", 32'(i_addr), 32'h36);
    chk("bznt_flush",  32'(flush), 32'h0);
    mem_ir = 16'h0;

    // HALT at 0x0A, then JMPR out
    mem_ir = {OP_JMPR, 11'h0}; reg_C = 16'h000A;
    tick();
    mem_ir = 16'h0;
    tick();
    chk("halt_in_id", 32'(id_pc), 32'h0A);
    tick();
    chk("halt_set",    32'(halted), 32'h1);
    chk("halt_i_addr", 32'(i_addr), 32'h0B);
    chk("halt_valid",  32'(id_valid), 32'h0);
    tick();
    chk("halt_frozen", 32'(i_addr), 32'h0B);
    mem_ir = {OP_JMPR, 11'h0}; reg_C = 16'h0020;
    tick();
    chk("unhalt",        32'(halted), 32'h0);
    chk("unhalt_i_addr", 32'(i_addr), 32'h20);
    mem_ir = 16'h0;

    // state=0 ignores a taken branch
    mem_ir = {OP_BZ, 11'h0}; zf = 1; reg_C = 16'h0099; state = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_i_addr", 32'(i_addr), 32'h20);
      chk("hold_flush",  32'(flush), 32'h0);
    end
    state = 1; mem_ir = 16'h0; zf = 0;

    // pc wrap
    mem_ir = {OP_JMPR, 11'h0}; reg_C = 16'h00FF;
    tick();
    mem_ir = 16'h0;
    tick();
    chk("wrap_i_addr", 32'(i_addr), 32'h00);
    chk("wrap_id_pc",  32'(id_pc), 32'hFF);

    // reset during HALT
    mem_ir = {OP_JMPR, 11'h0}; reg_C = 16'h000A;
    tick();
    mem_ir = 16'h0;
    tick();
    tick();
    chk("halt2_set", 32'(halted), 32'h1);
    reset = 1;
    tick();
    chk("rst_halt_halted", 32'(halted), 32'h0);
    chk("rst_halt_i_addr", 32'(i_addr), 32'h0);
    chk("rst_halt_id_ir",  32'(id_ir), 32'h0);
    reset = 0;

    // randomized phase
    for (int i = 0; i < 256; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)      w = {OP_JUMP, 3'b000, 8'($urandom)};
      else if (r == 1) w = {OP_HALT, 11'h0};
      else             w = {5'($urandom_range(1, 15)), 11'($urandom)};
      imem[i] = w;
    end
    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        case (r)
          0: w = {OP_BZ, 11'h0};
          1: w = {OP_BNZ, 11'h0};
          2: w = {OP_BN, 11'h0};
          3: w = {OP_BNN, 11'h0};
          4: w = {OP_BC, 11'h0};
          5: w = {OP_BNC, 11'h0};
          default: w = {OP_JMPR, 11'h0};
        endcase
      end else begin
        w = {5'($urandom_range(1, 15)), 11'($urandom)};
      end
      mem_ir   = w;
      reg_C    = 16'($urandom);
      zf       = 1'($urandom);
      nf       = 1'($urandom);
      cf       = 1'($urandom);
      id_ready = ($urandom_range(0, 3) != 0);
      state    = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage, successor to the current 8-bit IF stage. Owns the PC and drives the combinational instruction memory. Presents one instruction per cycle to ID with a valid/ready stall handshake, and resolves JUMP in ID and conditional branches/JMPR in MEM. Adds wrong-path squashing, a flush pulse for downstream stages, and a HALT state.

## Interface
- PC_W, 8, PC and i_addr width; must be ≤ IR_W−OP_W
- IR_W, 16, instruction width
- OP_W, 5, opcode field width, located at ir[IR_W-1 -: OP_W]
- DATA_W, 16, register width of reg_C
- RESET_PC, 0, PC value after reset
- NOP_IR, 0, instruction word injected as a bubble

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- state  in  1  1 = exec (advance), 0 = hold every register
- id_ready  in  1  ID accepts id_ir this cycle; 0 = stall
- mem_ir  in  IR_W  instruction currently in MEM
- reg_C  in  DATA_W  branch/JMPR target; low PC_W bits used
- zf, nf, cf  in  1 each  flags for the MEM-stage branch
- i_datain  in  IR_W  instruction at i_addr, same cycle
- i_addr  out  PC_W  equals pc register
- id_ir  out  IR_W  instruction to ID
- id_pc  out  PC_W  address of id_ir
- id_valid  out  1  id_ir is a real instruction
- flush  out  1  one-cycle pulse: ID/EX must squash their contents
- halted  out  1  FSM in HALT

## Operation
- FSM states:
  - RUN (reset state)
  - HALT: entered when the ID instruction is HALT, id_valid=1, id_ready=1, and there is no MEM redirect.
- Redirect conditions:
  - mem_redirect = (BZ&zf) | (BNZ&!zf) | (BN&nf) | (BNN&!nf) | (BC&cf) | (BNC&!cf) | JMPR, decoded from mem_ir.
  - id_jump = id_valid & id_ir opcode == JUMP.
- Per-cycle priority when state=1:
  1. mem_redirect: pc←reg_C[PC_W-1:0]; id_ir←NOP_IR, id_valid←0; flush←1; FSM→RUN. Overrides stall and HALT.
  2. HALT: hold pc; id_ir←NOP_IR, id_valid←0.
  3. !id_ready: hold pc, id_ir, id_pc, id_valid.
  4. id_jump: pc←id_ir[PC_W-1:0]; id_ir←NOP_IR, id_valid←0. The wrong-path fetch is squashed, so there is no delay slot.
  5. Otherwise: id_ir←i_datain, id_pc←pc, id_valid←1, pc←pc+1.
- flush is 0 in every cycle not covered by rule 1.
- state=0: all registers hold, flush←0.
- pc+1 wraps modulo 2^PC_W (0xFF→0x00 at PC_W=8).
- Reset values: pc=RESET_PC, id_ir=NOP_IR, id_pc=0, id_valid=0, flush=0, halted=0, FSM=RUN. Reset mid-stall or mid-HALT behaves identically.

## Timing
- i_addr is combinational from the pc register. Instruction memory is combinational, so fetch latency is 0 cycles and an instruction reaches id_ir at the next edge.
- Redirect penalty:
  - MEM branch: target appears on i_addr the cycle after resolution and in id_ir one cycle later.
  - ID JUMP: one bubble.
- flush is registered and asserted exactly in the cycle the redirect target is on i_addr.
- A stall coinciding with a MEM redirect has no effect: the redirect wins.
- A JUMP in ID together with a MEM redirect: the MEM redirect wins and the JUMP is discarded.
- Branches in MEM with state=0 are ignored. MEM must hold mem_ir until state=1.

## Structure
- Shared define/package holds:
  - Opcodes: JUMP, JMPR, BZ, BNZ, BN, BNN, BC, BNC, HALT.
  - The exec state encoding.
  - FSM state encodings RUN/HALT.
- Sub-module if_branch_resolve is purely combinational: (mem_ir, zf, nf, cf) → mem_redirect.
- PC, pipeline register and FSM stay in if_fetch_unit.

## Test plan
- Reset, then 4 cycles with state=1, id_ready=1:
  - i_addr 0,1,2,3.
  - id_pc 0,1,2 with id_valid=1.
  - flush=0 throughout.
- id_ready=0 for 3 cycles at pc=5:
  - i_addr stays 5; id_ir/id_pc stay constant.
  - Release: pc→6 next edge.
- JUMP with target 0x40 in ID:
  - Next cycle: i_addr=0x40, id_valid=0.
  - Following cycle: id_pc=0x40.
- BZ in MEM with zf=1, reg_C=0x1234, id_ready=0:
  - i_addr=0x34, flush=1 for exactly one cycle, id_valid=0.
  - Same stimulus with zf=0: sequential, flush=0.
- HALT accepted at pc=0x0A:
  - halted=1; i_addr frozen at 0x0B; id_valid=0.
  - JMPR in MEM with reg_C=0x20 → halted=0, i_addr=0x20.
- pc=0xFF sequential → i_addr 0x00. Reset asserted during HALT → all outputs at reset values on the next edge.
